ram_16x8: RTL and testbench



---
 rtl/ram_16x8.sv | 42 ++++
 tb/tb_ram_16x8.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_16x8.sv
// ram_16x8: single-port synchronous RAM with one shared address bus.
// The RW input picks write (1) or read (0) every cycle. Read data comes out of a register.
//
// Interface timing: there is no valid/ready handshake. The RAM is always ready.
// Every rising edge of clk with rst=0 carries out exactly one operation:
//   - RW=1: mem[address] <= datain, and dataout keeps its previous value.
//   - RW=0: dataout <= mem[address], so the data appears one cycle after the address.
// A rising edge with rst=1 clears the array and dataout, and ignores RW, address and datain.
module ram_16x8 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RW,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] datain,
    output logic [DATA_WIDTH-1:0] dataout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage array. Every address code is in range, so no bounds logic is needed.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset clears the whole array and takes priority over any read or write.
    // Otherwise a write updates one word and leaves dataout alone,
    // and a read loads the dataout register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dataout <= '0;
        end else if (RW) begin
            mem[address] <= datain;
        end else begin
            dataout <= mem[address];
        end
    end

endmodule

// File: tb/tb_ram_16x8.sv
// tb_ram_16x8: self-checking bench for ram_16x8.
// A reference model computes the expected dataout for every driven cycle and pushes it to exp_q.
// Each test task pops that value and compares it against the DUT after the edge.
module tb_ram_16x8;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    typedef struct packed {
        logic          r;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          rw;
    logic [AW-1:0] address;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;

    always #5 clk = ~clk;

    ram_16x8 #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .RW     (rw),
        .address(address),
        .datain (datain),
        .dataout(dataout)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_mem[DEPTH];
    logic [DW-1:0] model_out;
    int            n_checks = 0;
    int            n_fail   = 0;

    // ---------------- driver ----------------
    // Drives one cycle of stimulus and updates the model.
    // It pushes the dataout value expected after the edge, then returns #1 after that edge.
    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst     = r;
        rw      = w;
        address = a;
        datain  = d;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            model_out = '0;
        end else if (w) begin
            model_mem[a] = d;
        end else begin
            model_out = model_mem[a];
        end
        exp_q.push_back(model_out);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        op_t           ops[4];
        logic [DW-1:0] exp;
        ops = '{'{1'b1, 1'b0, 4'd0, 8'h00},
                '{1'b0, 1'b1, 4'd3, 8'hA5},
                '{1'b1, 1'b0, 4'd0, 8'h00},
                '{1'b0, 1'b0, 4'd3, 8'h00}};
        foreach (ops[i]) begin
            drive(ops[i].r, ops[i].w, ops[i].a, ops[i].d);
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL reset step %0d: dataout=%h expected=%h", i, dataout, exp);
            end
        end
    endtask

    task automatic test_basic;
        op_t           ops[4];
        logic [DW-1:0] exp;
        ops = '{'{1'b0, 1'b1, 4'd0, 8'hFF},
                '{1'b0, 1'b1, 4'd1, 8'hF8},
                '{1'b0, 1'b0, 4'd0, 8'h00},
                '{1'b0, 1'b0, 4'd1, 8'h00}};
        foreach (ops[i]) begin
            drive(ops[i].r, ops[i].w, ops[i].a, ops[i].d);
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL basic step %0d: dataout=%h expected=%h", i, dataout, exp);
            end
        end
    endtask

    task automatic test_overwrite;
        op_t           ops[3];
        logic [DW-1:0] exp;
        ops = '{'{1'b0, 1'b1, 4'd0, 8'h01},
                '{1'b0, 1'b0, 4'd0, 8'h00},
                '{1'b0, 1'b0, 4'd1, 8'h00}};
        foreach (ops[i]) begin
            drive(ops[i].r, ops[i].w, ops[i].a, ops[i].d);
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL overwrite step %0d: dataout=%h expected=%h", i, dataout, exp);
            end
        end
    endtask

    task automatic test_write_hold;
        op_t           ops[3];
        logic [DW-1:0] exp;
        ops = '{'{1'b0, 1'b0, 4'd1, 8'h00},
                '{1'b0, 1'b1, 4'd2, 8'h55},
                '{1'b0, 1'b0, 4'd2, 8'h00}};
        foreach (ops[i]) begin
            drive(ops[i].r, ops[i].w, ops[i].a, ops[i].d);
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL write_hold step %0d: dataout=%h expected=%h", i, dataout, exp);
            end
        end
    endtask

    task automatic test_sweep;
        logic [DW-1:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, AW'(i), DW'(i) ^ 8'h5A);
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL sweep_write addr %0d: dataout=%h expected=%h", i, dataout, exp);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            drive(1'b0, 1'b0, AW'(i), $urandom_range(0, 255));
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL sweep_read addr %0d: dataout=%h expected=%h", i, dataout, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp;
        for (int i = 0; i < 8; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, DEPTH - 1));
            drive(1'b0, 1'b1, a, DW'($urandom_range(0, 255)));
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL b2b_write addr %0d: dataout=%h expected=%h", a, dataout, exp);
            end
            drive(1'b0, 1'b0, a, 8'h00);
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL b2b_read addr %0d: dataout=%h expected=%h", a, dataout, exp);
            end
        end
    endtask

    task automatic test_reset_priority;
        op_t           ops[3];
        logic [DW-1:0] exp;
        ops = '{'{1'b1, 1'b1, 4'd4, 8'h3C},
                '{1'b0, 1'b0, 4'd4, 8'h00},
                '{1'b0, 1'b0, 4'd0, 8'h00}};
        foreach (ops[i]) begin
            drive(ops[i].r, ops[i].w, ops[i].a, ops[i].d);
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL reset_priority step %0d: dataout=%h expected=%h", i, dataout, exp);
            end
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] exp;
        logic          w;
        logic [AW-1:0] a;
        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 1) == 1);
            a = AW'($urandom_range(0, DEPTH - 1));
            drive(($urandom_range(0, 60) == 0), w, a, DW'($urandom_range(0, 255)));
            exp = exp_q.pop_front();
            n_checks++;
            if (dataout !== exp) begin
                n_fail++;
                $display("FAIL random op %0d addr %0d: dataout=%h expected=%h", i, a, dataout, exp);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst     = 1'b1;
        rw      = 1'b0;
        address = '0;
        datain  = '0;
        test_reset();
        test_basic();
        test_overwrite();
        test_write_hold();
        test_sweep();
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
